reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised two-write / two-read register file for the RV32IM pipeline's decode stage. It generalises the original 32×32 register file in width and depth and adds a second write port with fixed priority and write-to-read bypass. It also provides registered (stall-able) read outputs, an optional hardwired-zero entry, and a multi-cycle clear sweep that pipeline flush logic can trigger without a global reset.

## Interface
- WIDTH, 32, data width of every entry and port
- DEPTH, 32, number of entries (≥2); AW = $clog2(DEPTH) is derived, not a parameter
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes (RISC-V x0)
- CLOCK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high; overrides every other input
- WRITE1  in  1  write enable, port 1
- INADDRESS1  in  AW  write address, port 1
- IN1  in  WIDTH  write data, port 1
- WRITE2  in  1  write enable, port 2 (priority port)
- INADDRESS2  in  AW  write address, port 2
- IN2  in  WIDTH  write data, port 2
- OUT1ADDRESS, OUT2ADDRESS  in  AW  read addresses
- READ_EN  in  1  load read registers; low = hold (stall)
- CLEAR  in  1  request a clear sweep of all entries
- OUT1, OUT2  out  WIDTH  registered read data
- BUSY  out  1  clear sweep in progress

## Operation
- RESET=1 at an edge: all entries ← 0; OUT1/OUT2 ← 0; BUSY ← 0; FSM ← IDLE; sweep pointer ← 0. This applies even mid-sweep.
- Effective write, port k: WRITEk=1, BUSY=0, INADDRESSk < DEPTH, and not (ZERO_REG=1 and INADDRESSk=0). Writes that fail any condition are silently dropped.
- Both ports write the same address on one edge: port 2 data stored; port 1 dropped.
- Read, READ_EN=1 at edge, per output j:
  - OUTj ← 0 if BUSY=1, or OUTjADDRESS ≥ DEPTH, or (ZERO_REG=1 and OUTjADDRESS=0).
  - Otherwise OUTj ← IN2 if there is an effective port-2 write to that address this edge.
  - Otherwise OUTj ← IN1 if there is an effective port-1 write to that address this edge.
  - Otherwise OUTj ← stored entry.
- READ_EN=0: OUT1/OUT2 hold; writes and the sweep proceed normally.
- Clear FSM, states IDLE and SWEEP:
  - IDLE with CLEAR=1: → SWEEP, pointer ← 0, BUSY ← 1.
  - SWEEP: each edge entry[pointer] ← 0, pointer ← pointer+1. On the edge that clears entry DEPTH-1 → IDLE, BUSY ← 0, pointer ← 0.
  - CLEAR while in SWEEP is ignored (no restart).
- With ZERO_REG=1, entry 0 is never written, so clearing it is harmless.

## Timing
- Write latency: data written at edge N is stored after N. A read at edge N of the same address returns the new data via bypass (read-after-write in same cycle = 0 stall).
- Read latency: 1 cycle; OUTj reflects addresses sampled at edge N, valid after N.
- Clear: CLEAR sampled at edge N (IDLE) → BUSY=1 after N. Entries 0..DEPTH-1 are zeroed on edges N+1..N+DEPTH; BUSY=0 after N+DEPTH. Total BUSY = DEPTH cycles.
- A write accepted on edge N (BUSY still 0) is stored, then zeroed by the sweep.
- First write accepted after a sweep: edge N+DEPTH+1.
- RESET asserted for one edge is sufficient; outputs are 0 on the next cycle.

## Test plan
- Reset: preload entries 3 and 7, assert RESET one edge, read 3 and 7 → OUT1=OUT2=0, BUSY=0.
- Basic write/read: WRITE1 addr 2 data 95, next edge read OUT1ADDRESS=2 → OUT1=95 one cycle after the read edge.
- Bypass and priority: same edge WRITE1 addr 5=28, WRITE2 addr 5=50, OUT1ADDRESS=OUT2ADDRESS=5 → OUT1=OUT2=50 after that edge; later read of 5 → 50.
- Zero register: ZERO_REG=1, WRITE2 addr 0 data 0xDEADBEEF, read 0 → 0. Repeat with ZERO_REG=0 → 0xDEADBEEF.
- Stall: load OUT1=95, drop READ_EN, change OUT1ADDRESS and write new data to addr 2 → OUT1 stays 95 until READ_EN=1.
- Clear sweep: fill all entries with nonzero values, pulse CLEAR.
  - BUSY high exactly DEPTH cycles; writes during BUSY dropped; reads during BUSY → 0.
  - After BUSY falls, every entry reads 0.
  - Repeat with RESET mid-sweep (at pointer=10) → BUSY=0 next cycle, all entries 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised 2-write / 2-read register file for decode.
// Ports: CLOCK, RESET (sync, active-high); write ports 1 and 2
//   (WRITEk, INADDRESSk, INk; port 2 wins on address collision);
//   read addresses OUT1ADDRESS/OUT2ADDRESS, READ_EN (low = hold),
//   CLEAR (start zeroing sweep); outputs OUT1/OUT2 (registered),
//   BUSY (sweep in progress).
module reg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             WRITE1,
    input  logic [AW-1:0]    INADDRESS1,
    input  logic [WIDTH-1:0] IN1,
    input  logic             WRITE2,
    input  logic [AW-1:0]    INADDRESS2,
    input  logic [WIDTH-1:0] IN2,
    input  logic [AW-1:0]    OUT1ADDRESS,
    input  logic [AW-1:0]    OUT2ADDRESS,
    input  logic             READ_EN,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2,
    output logic             BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    ptr, ptr_nxt;
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic             we1, we2;
    logic             last;
    logic [WIDTH-1:0] rd1, rd2;

    assign BUSY = (state == SWEEP);
    assign last = (int'(ptr) == DEPTH - 1);

    // Address is usable as a storage slot (in range, not hardwired x0).
    function automatic logic slot_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign we1 = WRITE1 && !BUSY && slot_ok(INADDRESS1);
    assign we2 = WRITE2 && !BUSY && slot_ok(INADDRESS2);

    // Read mux with write-to-read bypass; port 2 has priority.
    function automatic logic [WIDTH-1:0] read_val(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (BUSY || !slot_ok(a))
            v = '0;
        else if (we2 && (INADDRESS2 == a))
            v = IN2;
        else if (we1 && (INADDRESS1 == a))
            v = IN1;
        else
            v = mem[a];
        return v;
    endfunction

    always_comb begin
        rd1 = read_val(OUT1ADDRESS);
        rd2 = read_val(OUT2ADDRESS);
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (CLEAR) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                if (last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Storage: sweep and writes are mutually exclusive since writes
    // are gated by BUSY; port 2 is applied last so it wins.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (state == SWEEP)
                mem[ptr] <= '0;
            if (we1)
                mem[INADDRESS1] <= IN1;
            if (we2)
                mem[INADDRESS2] <= IN2;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            OUT1 <= '0;
            OUT2 <= '0;
        end else if (READ_EN) begin
            OUT1 <= rd1;
            OUT2 <= rd2;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp.
// Two instances share stimulus: ZERO_REG=1 (dut) and ZERO_REG=0 (dutz).
module tb_reg_file_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          CLOCK = 1'b0;
    logic          RESET, WRITE1, WRITE2, READ_EN, CLEAR;
    logic [AW-1:0] INADDRESS1, INADDRESS2, OUT1ADDRESS, OUT2ADDRESS;
    logic [W-1:0]  IN1, IN2;
    logic [W-1:0]  OUT1, OUT2, zOUT1, zOUT2;
    logic          BUSY, zBUSY;

    int checks   = 0;
    int failures = 0;

    always #5 CLOCK = ~CLOCK;

    reg_file_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .WRITE1(WRITE1), .INADDRESS1(INADDRESS1), .IN1(IN1),
        .WRITE2(WRITE2), .INADDRESS2(INADDRESS2), .IN2(IN2),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .READ_EN(READ_EN), .CLEAR(CLEAR),
        .OUT1(OUT1), .OUT2(OUT2), .BUSY(BUSY)
    );

    reg_file_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) dutz (
        .CLOCK(CLOCK), .RESET(RESET),
        .WRITE1(WRITE1), .INADDRESS1(INADDRESS1), .IN1(IN1),
        .WRITE2(WRITE2), .INADDRESS2(INADDRESS2), .IN2(IN2),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .READ_EN(READ_EN), .CLEAR(CLEAR),
        .OUT1(zOUT1), .OUT2(zOUT2), .BUSY(zBUSY)
    );

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle_inputs();
        RESET = 0; WRITE1 = 0; WRITE2 = 0; READ_EN = 1; CLEAR = 0;
        INADDRESS1 = '0; INADDRESS2 = '0; IN1 = '0; IN2 = '0;
        OUT1ADDRESS = '0; OUT2ADDRESS = '0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < D; i++) begin
            WRITE1 = 1; INADDRESS1 = AW'(i); IN1 = 32'h1000 + i;
            tick();
        end
        WRITE1 = 0;
    endtask

    task automatic test_reset();
        RESET = 1;
        tick();
        RESET = 0;
        checks++;
        if (OUT1 !== '0 || OUT2 !== '0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL init_reset: got %h %h %b want 0 0 0",
                     OUT1, OUT2, BUSY);
        end
        WRITE1 = 1; INADDRESS1 = 3; IN1 = 32'h33;
        WRITE2 = 1; INADDRESS2 = 7; IN2 = 32'h77;
        tick();
        WRITE1 = 0; WRITE2 = 0;
        OUT1ADDRESS = 3; OUT2ADDRESS = 7;
        tick();
        checks++;
        if (OUT1 !== 32'h33 || OUT2 !== 32'h77) begin
            failures++;
            $display("FAIL preload: got %h %h want 33 77", OUT1, OUT2);
        end
        RESET = 1;
        tick();
        RESET = 0;
        checks++;
        if (OUT1 !== '0 || OUT2 !== '0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: got %h %h %b want 0 0 0",
                     OUT1, OUT2, BUSY);
        end
        tick();
        checks++;
        if (OUT1 !== '0 || OUT2 !== '0) begin
            failures++;
            $display("FAIL reset_mem: got %h %h want 0 0", OUT1, OUT2);
        end
    endtask

    task automatic test_basic();
        WRITE1 = 1; INADDRESS1 = 2; IN1 = 32'd95;
        tick();
        WRITE1 = 0;
        OUT1ADDRESS = 2;
        tick();
        checks++;
        if (OUT1 !== 32'd95) begin
            failures++;
            $display("FAIL basic_rw: got %0d want 95", OUT1);
        end
    endtask

    task automatic test_bypass();
        WRITE1 = 1; INADDRESS1 = 5; IN1 = 32'd28;
        WRITE2 = 1; INADDRESS2 = 5; IN2 = 32'd50;
        OUT1ADDRESS = 5; OUT2ADDRESS = 5;
        tick();
        WRITE1 = 0; WRITE2 = 0;
        checks++;
        if (OUT1 !== 32'd50 || OUT2 !== 32'd50) begin
            failures++;
            $display("FAIL bypass_prio: got %0d %0d want 50 50", OUT1, OUT2);
        end
        OUT2ADDRESS = 2;
        tick();
        checks++;
        if (OUT1 !== 32'd50 || OUT2 !== 32'd95) begin
            failures++;
            $display("FAIL stored_prio: got %0d %0d want 50 95", OUT1, OUT2);
        end
        WRITE1 = 1; INADDRESS1 = 9; IN1 = 32'd11;
        WRITE2 = 1; INADDRESS2 = 10; IN2 = 32'd22;
        OUT1ADDRESS = 9; OUT2ADDRESS = 10;
        tick();
        WRITE1 = 0; WRITE2 = 0;
        checks++;
        if (OUT1 !== 32'd11 || OUT2 !== 32'd22) begin
            failures++;
            $display("FAIL bypass_split: got %0d %0d want 11 22", OUT1, OUT2);
        end
    endtask

    task automatic test_zero_reg();
        WRITE2 = 1; INADDRESS2 = 0; IN2 = 32'hDEADBEEF;
        OUT2ADDRESS = 0;
        tick();
        WRITE2 = 0;
        checks++;
        if (OUT2 !== '0 || zOUT2 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL zero_bypass: got %h %h want 0 deadbeef",
                     OUT2, zOUT2);
        end
        OUT1ADDRESS = 0;
        tick();
        checks++;
        if (OUT1 !== '0 || zOUT1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL zero_stored: got %h %h want 0 deadbeef",
                     OUT1, zOUT1);
        end
    endtask

    task automatic test_stall();
        OUT1ADDRESS = 2;
        tick();
        READ_EN = 0;
        OUT1ADDRESS = 5;
        WRITE1 = 1; INADDRESS1 = 2; IN1 = 32'd123;
        tick();
        WRITE1 = 0;
        checks++;
        if (OUT1 !== 32'd95) begin
            failures++;
            $display("FAIL stall_hold: got %0d want 95", OUT1);
        end
        OUT1ADDRESS = 2;
        tick();
        checks++;
        if (OUT1 !== 32'd95) begin
            failures++;
            $display("FAIL stall_hold2: got %0d want 95", OUT1);
        end
        READ_EN = 1;
        tick();
        checks++;
        if (OUT1 !== 32'd123) begin
            failures++;
            $display("FAIL stall_release: got %0d want 123", OUT1);
        end
    endtask

    task automatic test_clear();
        int cnt;
        int bad;
        fill_all();
        CLEAR = 1;
        tick();
        CLEAR = 0;
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL clear_start: got busy=%b want 1", BUSY);
        end
        // Writes and reads attempted throughout the sweep; CLEAR
        // re-pulsed mid-sweep must not restart it.
        WRITE1 = 1; INADDRESS1 = 4; IN1 = 32'hBAD;
        WRITE2 = 1; INADDRESS2 = 31; IN2 = 32'hBAD2;
        OUT1ADDRESS = 6; OUT2ADDRESS = 31;
        cnt = 1;
        bad = 0;
        while (BUSY === 1'b1 && cnt < 100) begin
            CLEAR = (cnt >= 5 && cnt < 10);
            tick();
            if (OUT1 !== '0 || OUT2 !== '0) bad++;
            if (BUSY === 1'b1) cnt++;
        end
        WRITE1 = 0; WRITE2 = 0; CLEAR = 0;
        checks++;
        if (cnt != D) begin
            failures++;
            $display("FAIL busy_len: got %0d cycles want %0d", cnt, D);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_reads: got %0d nonzero want 0", bad);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL no_restart: got busy=%b want 0", BUSY);
        end
        bad = 0;
        for (int i = 0; i < D; i++) begin
            OUT1ADDRESS = AW'(i); OUT2ADDRESS = AW'(i);
            tick();
            if (OUT1 !== '0 || zOUT2 !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clear_all: got %0d nonzero want 0", bad);
        end
        WRITE1 = 1; INADDRESS1 = 12; IN1 = 32'h55;
        tick();
        WRITE1 = 0;
        OUT1ADDRESS = 12;
        tick();
        checks++;
        if (OUT1 !== 32'h55) begin
            failures++;
            $display("FAIL post_clear_wr: got %h want 55", OUT1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int bad;
        fill_all();
        CLEAR = 1;
        tick();
        CLEAR = 0;
        repeat (10) tick();
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: got busy=%b want 1", BUSY);
        end
        RESET = 1;
        tick();
        RESET = 0;
        checks++;
        if (BUSY !== 1'b0 || OUT1 !== '0 || OUT2 !== '0) begin
            failures++;
            $display("FAIL mid_reset: got %b %h %h want 0 0 0",
                     BUSY, OUT1, OUT2);
        end
        bad = 0;
        for (int i = 0; i < D; i++) begin
            OUT1ADDRESS = AW'(i); OUT2ADDRESS = AW'(i);
            tick();
            if (OUT1 !== '0 || zOUT2 !== '0 || BUSY !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_reset_mem: got %0d nonzero want 0", bad);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_bypass();
        test_zero_reg();
        test_stall();
        test_clear();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
